// File: rtl/uart_tx_serializer_if.sv
// Host-to-serializer transmit bundle: parallel byte handshake in, serial line and status out.
// Latency: none (wires only).
// Backpressure: BUSY high means DATA_VALID is ignored; the host must wait for BUSY low.
//
// Signals:
//   TX_tick    1-CLK baud-oversample enable shared with the receive path
//   P_DATA     byte to send, sampled only on the accept cycle
//   DATA_VALID request to start a frame with P_DATA
//   PAR_TYP    0 = even parity, 1 = odd parity
//   TX_OUT     serial line, idle high
//   BUSY       frame in progress
//   TX_DONE    one-CLK pulse when the last stop bit ends
interface uart_tx_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  TX_tick;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  DATA_VALID;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  BUSY;
    logic                  TX_DONE;

    modport master (
        output TX_tick,
        output P_DATA,
        output DATA_VALID,
        output PAR_TYP,
        input  TX_OUT,
        input  BUSY,
        input  TX_DONE
    );

    modport slave (
        input  TX_tick,
        input  P_DATA,
        input  DATA_VALID,
        input  PAR_TYP,
        output TX_OUT,
        output BUSY,
        output TX_DONE
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit framer: start bit, DATA_WIDTH data bits LSB first, optional parity, STOP_BITS stop bits.
// Latency: TX_OUT drops to the start bit one CLK after DATA_VALID is accepted; each bit lasts OVERSAMPLE ticks.
// Backpressure: no buffering; DATA_VALID while BUSY is dropped, next accept possible on the TX_DONE cycle.
//
// Ports:
//   CLK  system clock
//   RST  asynchronous active-low reset; returns the line high and abandons any frame
//   bus  uart_tx_serializer_if.slave (TX_tick, P_DATA, DATA_VALID, PAR_TYP in; TX_OUT, BUSY, TX_DONE out)
//
// Build option: define UART_TX_PARITY_EN to insert one parity bit after the data bits.
// Without it the parity state and logic are absent and PAR_TYP is unused.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    uart_tx_serializer_if.slave  bus
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_WIDTH);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  tx_out_q, tx_out_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  bit_end;

`ifdef UART_TX_PARITY_EN
    // Parity is resolved at accept time so the PARITY state only has to replay one flop.
    logic                  par_q, par_d;
`else
    logic                  unused_par_typ;
    assign unused_par_typ = bus.PAR_TYP;
`endif

    // A bit period ends on the tick that finds the counter at its last value.
    assign bit_end = bus.TX_tick && (cnt_q == CNT_LAST);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d    = par_q;
`endif

        // Ticks are counted only inside a frame, so a tick on the accept cycle is not counted.
        if (state_q != IDLE && bus.TX_tick) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bus.DATA_VALID) begin
                    state_d = START;
                    shift_d = bus.P_DATA;
                    cnt_d   = '0;
                    idx_d   = '0;
`ifdef UART_TX_PARITY_EN
                    par_d   = (^bus.P_DATA) ^ bus.PAR_TYP;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    idx_d   = '0;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level is decoded from the next state so TX_OUT leaves a flop with no gating after it.
        tx_out_d = 1'b1;
        case (state_d)
            START:   tx_out_d = 1'b0;
            DATA:    tx_out_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_out_d = par_d;
`endif
            default: tx_out_d = 1'b1;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_out_q <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_out_q <= tx_out_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign bus.TX_OUT  = tx_out_q;
    assign bus.BUSY    = busy_q;
    assign bus.TX_DONE = done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Testbench for uart_tx_serializer: two instances (16x/1 stop and 4x/2 stop) driven by a shared tick.
// Expected frames are queued at accept time by a tick-counting model; a negedge monitor checks every line sample.
// Directed cases cover the plan scenarios, then randomized bytes, parity types, gaps and tick spacing.
module tb_uart_tx_serializer;

    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       typ;
        int         acc;
    } exp_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       tick;
    logic [7:0] pd [2];
    logic [1:0] dv;
    logic [1:0] pt;
    logic [1:0] line, busy, done;

    uart_tx_serializer_if #(.DATA_WIDTH(DW)) bus0 ();
    uart_tx_serializer_if #(.DATA_WIDTH(DW)) bus1 ();

    assign bus0.TX_tick    = tick;
    assign bus1.TX_tick    = tick;
    assign bus0.P_DATA     = pd[0];
    assign bus1.P_DATA     = pd[1];
    assign bus0.DATA_VALID = dv[0];
    assign bus1.DATA_VALID = dv[1];
    assign bus0.PAR_TYP    = pt[0];
    assign bus1.PAR_TYP    = pt[1];
    assign line = {bus1.TX_OUT, bus0.TX_OUT};
    assign busy = {bus1.BUSY, bus0.BUSY};
    assign done = {bus1.TX_DONE, bus0.TX_DONE};

    uart_tx_serializer #(.DATA_WIDTH(DW), .OVERSAMPLE(16), .STOP_BITS(1)) u_dut0 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus0)
    );

    uart_tx_serializer #(.DATA_WIDTH(DW), .OVERSAMPLE(4), .STOP_BITS(2)) u_dut1 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus1)
    );

    initial forever #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input bit ok, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int os_of(input int u);
        return (u == 0) ? 16 : 4;
    endfunction

    function automatic int sb_of(input int u);
        return (u == 0) ? 1 : 2;
    endfunction

    function automatic int nbits(input int u);
        return 1 + DW + PB + sb_of(u);
    endfunction

    // Frame bit idx: 0 start, 1..DW data LSB first, then parity (if built), then stop bits.
    function automatic logic bit_at(input logic [7:0] d, input logic typ, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DW) return d[idx-1];
        if (PB == 1 && idx == DW + 1) return (($countones(d) % 2) == 1) ^ typ;
        return 1'b1;
    endfunction

    // ---------------- reference model: accept decisions and frame duration in ticks ----------------
    exp_t q0[$];
    exp_t q1[$];
    bit   m_busy [2];
    int   left [2];
    int   acc_n [2];
    int   cyc = 0;

    initial begin
        exp_t e;
        forever begin
            @(posedge CLK or negedge RST);
            if (!RST) begin
                for (int u = 0; u < 2; u++) m_busy[u] = 1'b0;
                q0.delete();
                q1.delete();
            end else begin
                cyc++;
                for (int u = 0; u < 2; u++) begin
                    if (!m_busy[u]) begin
                        if (dv[u]) begin
                            e.data = pd[u];
                            e.typ  = pt[u];
                            e.acc  = cyc;
                            if (u == 0) q0.push_back(e);
                            else        q1.push_back(e);
                            m_busy[u] = 1'b1;
                            left[u]   = nbits(u) * os_of(u);
                            acc_n[u]++;
                        end
                    end else if (tick) begin
                        left[u]--;
                        if (left[u] == 0) m_busy[u] = 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit   in_f [2];
    bit   pend [2];
    int   ticks [2];
    int   lerr [2];
    exp_t cur [2];
    int   seen [2];
    int   aborted [2];
    int   idle_err [2];
    int   last_len [2];
    int   last_done [2];
    int   gap [2];

    initial begin
        int qs;
        for (int u = 0; u < 2; u++) last_done[u] = -1000;
        forever begin
            @(negedge CLK);
            for (int u = 0; u < 2; u++) begin
                if (!RST) begin
                    if (in_f[u]) aborted[u]++;
                    in_f[u] = 1'b0;
                    if (line[u] !== 1'b1 || busy[u] !== 1'b0 || done[u] !== 1'b0) idle_err[u]++;
                end else begin
                    if (in_f[u] && pend[u]) ticks[u]++;
                    if (!in_f[u]) begin
                        if (line[u] === 1'b0) begin
                            qs = (u == 0) ? q0.size() : q1.size();
                            chk("start_has_expectation", qs > 0, qs, 1);
                            if (qs > 0) begin
                                if (u == 0) cur[u] = q0.pop_front();
                                else        cur[u] = q1.pop_front();
                                chk("start_cycle", cyc == cur[u].acc, cyc, cur[u].acc);
                            end else begin
                                cur[u].data = 8'h00;
                                cur[u].typ  = 1'b0;
                                cur[u].acc  = cyc;
                            end
                            in_f[u]  = 1'b1;
                            ticks[u] = 0;
                            lerr[u]  = 0;
                            gap[u]   = cyc - last_done[u];
                        end else if (busy[u] !== 1'b0 || done[u] !== 1'b0) begin
                            idle_err[u]++;
                        end
                    end
                    if (in_f[u]) begin
                        if (ticks[u] < nbits(u) * os_of(u)) begin
                            if (line[u] !== bit_at(cur[u].data, cur[u].typ, ticks[u] / os_of(u)) ||
                                busy[u] !== 1'b1 || done[u] !== 1'b0)
                                lerr[u]++;
                        end else begin
                            chk("done_busy_line", done[u] === 1'b1 && busy[u] === 1'b0 && line[u] === 1'b1,
                                int'({done[u], busy[u], line[u]}), 5);
                            chk("frame_bits", lerr[u] == 0, lerr[u], 0);
                            if (lerr[u] != 0)
                                $display("  frame u%0d data=%02h typ=%0d", u, cur[u].data, cur[u].typ);
                            seen[u]++;
                            last_len[u]  = cyc - cur[u].acc;
                            last_done[u] = cyc;
                            in_f[u]      = 1'b0;
                        end
                    end
                end
                pend[u] = tick;
            end
        end
    end

    // ---------------- stimulus ----------------
    int ph = 0;
    int tgap = 0;
    bit rnd_mode = 1'b0;

    task automatic step();
        @(posedge CLK);
        #1;
        if (!rnd_mode) begin
            ph   = (ph + 1) % 4;
            tick = (ph == 0);
        end else if (tgap == 0) begin
            tick = 1'b1;
            tgap = $urandom_range(1, 5);
        end else begin
            tick = 1'b0;
            tgap--;
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // In fixed-tick mode the request is aligned with a tick so frame length in CLKs is exact.
    task automatic send(input int u, input logic [7:0] d, input logic typ);
        int g;
        g = 0;
        while (!rnd_mode && !tick && g < 8) begin
            step();
            g++;
        end
        pd[u] = d;
        pt[u] = typ;
        dv[u] = 1'b1;
        step();
        dv[u] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_busy[0] || m_busy[1] || in_f[0] || in_f[1]) && n < 20000) begin
            step();
            n++;
        end
        chk("idle_within_budget", n < 20000, n, 20000);
        run(3);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, s0, n;
        tick  = 1'b0;
        dv    = 2'b00;
        pt    = 2'b00;
        pd[0] = 8'h00;
        pd[1] = 8'h00;
        run(3);
        for (int u = 0; u < 2; u++) begin
            chk("reset_tx_out", line[u] === 1'b1, int'(line[u]), 1);
            chk("reset_busy",   busy[u] === 1'b0, int'(busy[u]), 0);
            chk("reset_done",   done[u] === 1'b0, int'(done[u]), 0);
        end
        @(negedge CLK);
        RST = 1'b1;
        run(5);

        // 0x55 with a tick every 4 CLK: bit period 64 CLK.
        send(0, 8'h55, 1'b0);
        wait_idle();
        chk("len_55", last_len[0] == nbits(0) * 64, last_len[0], nbits(0) * 64);

        // 0xA3 with even then odd parity.
        send(0, 8'hA3, 1'b0);
        wait_idle();
        send(0, 8'hA3, 1'b1);
        wait_idle();

        // 0xFF requested mid-frame must be dropped; P_DATA wiggle has no effect.
        s0 = seen[0];
        send(0, 8'h00, 1'b0);
        run(200);
        pd[0] = 8'hFF;
        dv[0] = 1'b1;
        step();
        dv[0] = 1'b0;
        run(50);
        pd[0] = 8'hC3;
        wait_idle();
        chk("drop_midframe", seen[0] == s0 + 1, seen[0] - s0, 1);

        // DATA_VALID held: 0x0F then 0xF0 back to back.
        n0 = acc_n[0];
        pd[0] = 8'h0F;
        dv[0] = 1'b1;
        n = 0;
        while (acc_n[0] < n0 + 1 && n < 100) begin step(); n++; end
        pd[0] = 8'hF0;
        n = 0;
        while (acc_n[0] < n0 + 2 && n < 3000) begin step(); n++; end
        dv[0] = 1'b0;
        chk("b2b_accepts", acc_n[0] == n0 + 2, acc_n[0] - n0, 2);
        wait_idle();
        chk("b2b_gap", gap[0] == 1, gap[0], 1);

        // Reset during data bit 3 abandons the frame; then 0x3C goes out cleanly.
        send(0, 8'h5A, 1'b0);
        run(288);
        RST = 1'b0;
        #1;
        chk("midreset_tx_out", line[0] === 1'b1, int'(line[0]), 1);
        chk("midreset_busy",   busy[0] === 1'b0, int'(busy[0]), 0);
        run(3);
        @(negedge CLK);
        RST = 1'b1;
        run(4);
        chk("abort_seen", aborted[0] == 1, aborted[0], 1);
        s0 = seen[0];
        send(0, 8'h3C, 1'b0);
        wait_idle();
        chk("after_reset_frame", seen[0] == s0 + 1, seen[0] - s0, 1);

        // Two stop bits, 4x oversample, tick every 4 CLK: 16 CLK per bit.
        send(1, 8'h81, 1'b0);
        wait_idle();
        chk("len_stop2", last_len[1] == nbits(1) * 16, last_len[1], nbits(1) * 16);

        // Random bytes, parity types, request timing and tick spacing.
        rnd_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            send($urandom_range(0, 1), 8'($urandom), 1'($urandom_range(0, 1)));
            run($urandom_range(0, 400));
        end
        wait_idle();

        for (int u = 0; u < 2; u++) begin
            chk("frames_accounted", seen[u] + aborted[u] == acc_n[u], seen[u] + aborted[u], acc_n[u]);
            chk("idle_clean", idle_err[u] == 0, idle_err[u], 0);
        end
        chk("queue0_empty", q0.size() == 0, q0.size(), 0);
        chk("queue1_empty", q1.size() == 0, q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

UART transmit framer and serializer for the UART block: accepts one parallel byte per handshake and drives a start bit, data bits LSB first, an optional parity bit, and stop bits onto the serial line. It is timed by the same 16x-oversampled baud tick the receive path uses, so both directions share one baud generator. It sits between the host-side transmit interface and the TX pad.

## Interface
- DATA_WIDTH, 8, data bits per frame (5–8 legal)
- OVERSAMPLE, 16, tick pulses per bit period (≥2)
- STOP_BITS, 1, stop bits per frame (1 or 2)

- CLK  input  1  system clock
- RST  input  1  reset, asynchronous, active-low
- TX_tick  input  1  one-CLK-wide baud-oversample enable
- P_DATA  input  DATA_WIDTH  byte to send
- DATA_VALID  input  1  P_DATA is valid
- PAR_TYP  input  1  0 = even parity, 1 = odd parity; ignored when parity is compiled out
- TX_OUT  output  1  serial line, idle high
- BUSY  output  1  frame in progress; DATA_VALID ignored while high
- TX_DONE  output  1  one-CLK pulse at end of frame

## Operation
- States: IDLE, START, DATA, PARITY (parity builds only), STOP.
- IDLE: TX_OUT=1, BUSY=0. In a cycle with DATA_VALID=1, latch P_DATA and PAR_TYP into the shift register, clear the tick counter and bit index, and go to START.
- START: TX_OUT=0.
- DATA: TX_OUT=shift[0]. Shift right at each bit boundary. Send DATA_WIDTH bits, LSB first.
- PARITY: TX_OUT = (^latched_data) XOR latched_PAR_TYP.
- STOP: TX_OUT=1 for STOP_BITS bit periods.
- Tick counter: width is clog2(OVERSAMPLE). It increments only on TX_tick. A bit boundary is a TX_tick with counter == OVERSAMPLE-1; the counter wraps to 0 there.
- A bit boundary advances START→DATA, DATA (last bit)→PARITY or STOP, PARITY→STOP, and STOP (last stop bit)→IDLE.
- On the STOP→IDLE boundary, TX_DONE=1 for exactly that one following cycle.
- DATA_VALID while BUSY=1 is dropped. There is no buffering. P_DATA changes mid-frame have no effect.
- All outputs are registered. TX_OUT comes directly from a flop, so the line is glitch-free.

## Timing
- Reset values: TX_OUT=1, BUSY=0, TX_DONE=0, state=IDLE, counters=0.
- Accept latency: DATA_VALID sampled high at edge N gives TX_OUT=0 and BUSY=1 after edge N.
- Bit period: exactly OVERSAMPLE TX_tick pulses, counted from the first TX_tick after accept.
- Frame length: (1 + DATA_WIDTH + P + STOP_BITS) × OVERSAMPLE ticks, where P=1 with parity, else 0.
- TX_DONE and BUSY→0 occur in the same cycle. The earliest next accept is at that cycle's edge, so back-to-back frames have no idle bit between them.
- TX_tick coinciding with the accept cycle is not counted.
- Reset asserted mid-frame: TX_OUT returns high asynchronously and the frame is abandoned. No TX_DONE is issued.
- TX_tick held low: the state freezes and TX_OUT holds its value.

## Configuration
- UART_TX_PARITY_EN defined: the PARITY state is present, PAR_TYP is honoured, and the frame carries one parity bit after the data bits.
- UART_TX_PARITY_EN undefined: the PARITY state and parity logic are removed and PAR_TYP is unused. The frame goes DATA→STOP directly.

## Test plan
- Defaults, no parity, P_DATA=0x55, one-cycle DATA_VALID, TX_tick every 4 CLK -> line reads 0,1,0,1,0,1,0,1,0,1. Each bit lasts 64 CLK. TX_DONE pulses once, 640 CLK after accept.
- UART_TX_PARITY_EN, P_DATA=0xA3, PAR_TYP=0 -> data bits 1,1,0,0,0,1,0,1, parity 0, stop 1. With PAR_TYP=1 and P_DATA=0xA3 -> parity 1.
- DATA_VALID=1 with P_DATA=0xFF asserted mid-frame while 0x00 is sending -> 0x00 frame completes unchanged and 0xFF is never sent.
- DATA_VALID held high, P_DATA=0x0F then 0xF0 -> accept on the TX_DONE cycle. The second start bit immediately follows the stop bit, and no TX_OUT high exceeds one bit period between frames.
- RST low during data bit 3 -> TX_OUT=1 and BUSY=0 at once, no TX_DONE. A fresh 0x3C frame after release transmits correctly.
- STOP_BITS=2, P_DATA=0x81 -> stop held high for 2×OVERSAMPLE ticks before TX_DONE.
